div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum cycles in BUSY before the abort path fires.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 req0, req1  in  1 each  divide request from pipe0 / pipe1; held high until done or cancel.
REQ-005 signed0, signed1  in  1 each  signed-divide select per requester.
REQ-006 op1_0, op2_0, op1_1, op2_1  in  32 each  dividend / divisor per requester.
REQ-007 cancel0, cancel1  in  1 each  flush of that requester's instruction.
REQ-008 stall0, stall1  out  1 each  requester must hold; high while req_i is high and done_i is not.
REQ-009 done0, done1  out  1 each  one-cycle result-valid pulse to the owning requester.
REQ-010 hi_o, lo_o  out  32 each  remainder / quotient, registered, held until the next done.
REQ-011 err_o  out  1  sticky timeout flag; cleared only by reset.
REQ-012 div_start, div_signed, div_annul, div_flush  out  1 each  divider control.
REQ-013 div_op1, div_op2  out  32 each  divider operands.
REQ-014 div_result  in  64  divider result: [63:32] remainder, [31:0] quotient.
REQ-015 div_ready  in  1  divider result ready; stays high while div_start is high.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, RELEASE and DRAIN, encoded as a 2-bit enum.
REQ-017 IDLE, with at least one req_i high and its cancel_i low: grant by round-robin; on a tie, pick the requester not granted last.
REQ-018 On grant:
  - latch owner id, signedness and operands into div_* registers;
  - assert div_start from the next cycle;
  - enter BUSY.
REQ-019 BUSY: div_start, div_op* and div_signed SHALL stay constant; the cycle counter increments each cycle.
REQ-020 BUSY with div_ready=1 and no cancel from the owner:
  - latch hi_o/lo_o from div_result;
  - pulse done_owner the next cycle;
  - drop div_start;
  - enter RELEASE.
REQ-021 RELEASE SHALL last exactly one cycle with div_start low, so the divider returns to free; then IDLE, with no grant in RELEASE.
REQ-022 Abort, when the owner's cancel_i is high in BUSY:
  - pulse div_flush for one cycle and drop div_start;
  - enter DRAIN; no done pulse, hi_o/lo_o unchanged.
REQ-023 DRAIN SHALL last one cycle with all div_* controls low, then IDLE.
REQ-024 Cycle counter reaches TIMEOUT in BUSY: take the abort path of REQ-022, set err_o, and pulse done_owner with hi_o=lo_o=0.
REQ-025 If cancel_i and div_ready are high in the same cycle, cancel wins: no done, the abort path is taken.
REQ-026 The non-owner requester SHALL see stall high for the whole BUSY/RELEASE/DRAIN window.
  - Its cancel_i only clears its own stall; it does not disturb the owner.
REQ-027 Divisor zero SHALL be passed through unchanged: the divider's zero result appears as hi_o=lo_o=0 with a normal done.
REQ-028 div_annul SHALL be tied low; abort uses div_flush only.
REQ-029 Latency: done_owner is high exactly one cycle after the first cycle div_ready is high in BUSY.
REQ-030 Nominal request-to-done latency SHALL be 37 cycles for a nonzero divisor and 5 cycles for a zero divisor.
REQ-031 A requester SHALL NOT be regranted in the cycle its done pulses; back-to-back same-requester operations are spaced by RELEASE.

Reset
REQ-032 While rst is low, state SHALL be IDLE, and these SHALL be 0: all outputs, hi_o, lo_o, err_o, and the cycle counter.
REQ-033 The round-robin pointer SHALL reset to favour pipe0.
REQ-034 Reset asserted mid-BUSY SHALL drop div_start immediately (asynchronously) and lose the operation; no done is produced.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the requester-id type (1 bit) and the TIMEOUT default.
REQ-036 div_arbiter SHALL instantiate no sub-modules; the divider is external and driven through the div_* ports.

Verification
REQ-037 req0=1, signed0=1, op1_0=-7, op2_0=2:
  - done0 is high 37 cycles later, with lo_o=0xFFFFFFFD and hi_o=0xFFFFFFFF;
  - stall0 is high until done0.
REQ-038 req0 and req1 rise together from reset:
  - pipe0 is served first, then pipe1;
  - the next tie is granted to pipe0 again after pipe1 was last served.
REQ-039 req1=1, op1_1=100, op2_1=0: done1 is high after 5 cycles with hi_o=lo_o=0, and err_o stays 0.
REQ-040 Owner cancel0 at cycle 10 of BUSY:
  - div_flush pulses once, and no done0 occurs;
  - two cycles later a pending req1 is granted and completes correctly.
REQ-041 Cancel and div_ready in the same cycle: no done pulse, and hi_o/lo_o keep their previous values.
REQ-042 The divider model is held with div_ready=0: after 40 BUSY cycles, err_o=1, done0 pulses with zeros, and the FSM returns to IDLE.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
// rtl/div_arbiter_pkg.sv - shared types and constants for the two-pipe divider arbiter
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef logic req_id_t;

  localparam int TIMEOUT_DEFAULT = 40;
  localparam int CNT_W           = 16;

  // Round-robin pick between two eligible requesters; a tie goes to the one not served last.
  function automatic req_id_t rr_pick(input logic elig0, input logic elig1, input req_id_t last);
    if (elig0 && elig1) return ~last;
    else if (elig1)     return 1'b1;
    else                return 1'b0;
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - requester, result and divider-control bundle for div_arbiter
interface div_arbiter_if;
  logic        req0, req1;
  logic        signed0, signed1;
  logic [31:0] op1_0, op2_0, op1_1, op2_1;
  logic        cancel0, cancel1;
  logic        stall0, stall1;
  logic        done0, done1;
  logic [31:0] hi_o, lo_o;
  logic        err_o;
  logic        div_start, div_signed, div_annul, div_flush;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;
  logic        div_ready;

  modport slave (
    input  req0, req1, signed0, signed1, op1_0, op2_0, op1_1, op2_1,
    input  cancel0, cancel1, div_result, div_ready,
    output stall0, stall1, done0, done1, hi_o, lo_o, err_o,
    output div_start, div_signed, div_annul, div_flush, div_op1, div_op2
  );

  modport master (
    output req0, req1, signed0, signed1, op1_0, op2_0, op1_1, op2_1,
    output cancel0, cancel1, div_result, div_ready,
    input  stall0, stall1, done0, done1, hi_o, lo_o, err_o,
    input  div_start, div_signed, div_annul, div_flush, div_op1, div_op2
  );
endinterface

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one external divider between two pipes
// Owner is held in BUSY until result, owner cancel, or timeout; RELEASE/DRAIN give the divider one idle cycle.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  div_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  req_id_t          owner_q, last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q, signed_q, flush_q, err_q;
  logic             done0_q, done1_q;
  logic [31:0]      op1_q, op2_q, hi_q, lo_q;

  logic    elig0, elig1, owner_cancel;
  req_id_t grant_id;

  assign elig0        = bus.req0 & ~bus.cancel0;
  assign elig1        = bus.req1 & ~bus.cancel1;
  assign grant_id     = rr_pick(elig0, elig1, last_q);
  assign owner_cancel = owner_q ? bus.cancel1 : bus.cancel0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      signed_q <= 1'b0;
      flush_q  <= 1'b0;
      err_q    <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      flush_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (elig0 || elig1) begin
            owner_q  <= grant_id;
            last_q   <= grant_id;
            signed_q <= grant_id ? bus.signed1 : bus.signed0;
            op1_q    <= grant_id ? bus.op1_1 : bus.op1_0;
            op2_q    <= grant_id ? bus.op2_1 : bus.op2_0;
            start_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // Cancel beats a same-cycle result; a same-cycle result beats the timeout.
          if (owner_cancel) begin
            flush_q  <= 1'b1;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            state_q  <= DRAIN;
          end else if (bus.div_ready) begin
            hi_q               <= bus.div_result[63:32];
            lo_q               <= bus.div_result[31:0];
            {done1_q, done0_q} <= owner_q ? 2'b10 : 2'b01;
            start_q            <= 1'b0;
            signed_q           <= 1'b0;
            state_q            <= RELEASE;
          end else if (cnt_q == TO_LAST) begin
            flush_q            <= 1'b1;
            start_q            <= 1'b0;
            signed_q           <= 1'b0;
            err_q              <= 1'b1;
            hi_q               <= '0;
            lo_q               <= '0;
            {done1_q, done0_q} <= owner_q ? 2'b10 : 2'b01;
            state_q            <= DRAIN;
          end
        end
        RELEASE: state_q <= IDLE;
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall0     = rst & bus.req0 & ~bus.cancel0 & ~done0_q;
  assign bus.stall1     = rst & bus.req1 & ~bus.cancel1 & ~done1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.err_o      = err_q;
  assign bus.div_start  = start_q;
  assign bus.div_signed = signed_q;
  assign bus.div_annul  = 1'b0;
  assign bus.div_flush  = flush_q;
  assign bus.div_op1    = op1_q;
  assign bus.div_op2    = op2_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter with a behavioural divider
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic hold;
  logic [7:0] dcnt;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_arbiter_if bus();

  div_arbiter #(.TIMEOUT(40)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // Divider model: result ready 35 cycles after start (3 for a zero divisor), unless held off.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              dcnt <= 8'd0;
    else if (!bus.div_start) dcnt <= 8'd0;
    else                     dcnt <= dcnt + 8'd1;
  end

  assign bus.div_ready = bus.div_start && !hold &&
                         (dcnt >= ((bus.div_op2 == 32'd0) ? 8'd3 : 8'd35));

  always_comb begin
    bus.div_result = 64'd0;
    if (bus.div_op2 == 32'd0)
      bus.div_result = 64'd0;
    else if (bus.div_signed)
      bus.div_result = {32'($signed(bus.div_op1) % $signed(bus.div_op2)),
                        32'($signed(bus.div_op1) / $signed(bus.div_op2))};
    else
      bus.div_result = {bus.div_op1 % bus.div_op2, bus.div_op1 / bus.div_op2};
  end

  task automatic wait_done(input bit which, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((which ? bus.done1 : bus.done0) === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b1;
    bus.op1_0 = 32'd9;
    bus.op2_0 = 32'd3;
    repeat (2) @(negedge clk);
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
    n_checks++; if (bus.div_start !== 1'b0) begin n_fail++; $display("FAIL reset_div_start: got %b expected 0", bus.div_start); end
    n_checks++; if (bus.stall0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall0: got %b expected 0", bus.stall0); end
    n_checks++; if ({bus.done0, bus.done1, bus.err_o, bus.div_flush, bus.div_annul} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {bus.done0, bus.done1, bus.err_o, bus.div_flush, bus.div_annul}); end
    n_checks++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {bus.hi_o, bus.lo_o}); end
    n_checks++; if (dut.cnt_q !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
    bus.req0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed();
    int c;
    int bad;
    bad = 0;
    c = -1;
    bus.req0 = 1'b1; bus.signed0 = 1'b1; bus.op1_0 = -32'sd7; bus.op2_0 = 32'd2;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done0 === 1'b1) begin c = i; break; end
      if (bus.stall0 !== 1'b1) bad++;
    end
    n_checks++; if (c != 37) begin n_fail++; $display("FAIL signed_latency: got %0d expected 37", c); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL signed_stall0: got %0d low cycles expected 0", bad); end
    n_checks++; if (bus.lo_o !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL signed_lo: got %h expected fffffffd", bus.lo_o); end
    n_checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL signed_hi: got %h expected ffffffff", bus.hi_o); end
    n_checks++; if (bus.stall0 !== 1'b0) begin n_fail++; $display("FAIL signed_stall_at_done: got %b expected 0", bus.stall0); end
    bus.req0 = 1'b0; bus.signed0 = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.done0 !== 1'b0) begin n_fail++; $display("FAIL signed_done_pulse: got %b expected 0", bus.done0); end
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL signed_release_to_idle: got %0d expected %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_round_robin();
    int c;
    do_reset();
    bus.req0 = 1'b1; bus.op1_0 = 32'd20; bus.op2_0 = 32'd3;
    bus.req1 = 1'b1; bus.op1_1 = 32'd50; bus.op2_1 = 32'd7;
    wait_done(1'b0, 60, c);
    n_checks++; if (c != 37) begin n_fail++; $display("FAIL rr_first_pipe0: got %0d expected 37", c); end
    n_checks++; if ({bus.hi_o, bus.lo_o} !== {32'd2, 32'd6}) begin n_fail++; $display("FAIL rr_first_result: got %h expected 0000000200000006", {bus.hi_o, bus.lo_o}); end
    n_checks++; if (bus.stall1 !== 1'b1) begin n_fail++; $display("FAIL rr_stall1: got %b expected 1", bus.stall1); end
    bus.req0 = 1'b0;
    wait_done(1'b1, 60, c);
    n_checks++; if (c != 38) begin n_fail++; $display("FAIL rr_second_pipe1: got %0d expected 38", c); end
    n_checks++; if ({bus.hi_o, bus.lo_o} !== {32'd1, 32'd7}) begin n_fail++; $display("FAIL rr_second_result: got %h expected 0000000100000007", {bus.hi_o, bus.lo_o}); end
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done(1'b0, 60, c);
    n_checks++; if (c != 37) begin n_fail++; $display("FAIL rr_tie_back_to_pipe0: got %0d expected 37", c); end
    bus.req0 = 1'b0;
    wait_done(1'b1, 60, c);
    n_checks++; if (c != 38) begin n_fail++; $display("FAIL rr_tie_then_pipe1: got %0d expected 38", c); end
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div_zero();
    int c;
    bus.req1 = 1'b1; bus.op1_1 = 32'd100; bus.op2_1 = 32'd0;
    wait_done(1'b1, 20, c);
    n_checks++; if (c != 5) begin n_fail++; $display("FAIL zero_latency: got %0d expected 5", c); end
    n_checks++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin n_fail++; $display("FAIL zero_result: got %h expected 0", {bus.hi_o, bus.lo_o}); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b expected 0", bus.err_o); end
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cancel();
    int c;
    bus.req0 = 1'b1; bus.op1_0 = 32'd1000; bus.op2_0 = 32'd10;
    bus.req1 = 1'b1; bus.op1_1 = 32'd81;   bus.op2_1 = 32'd9;
    repeat (10) @(negedge clk);
    bus.cancel0 = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.div_flush, bus.div_start, bus.done0} !== 3'b100) begin n_fail++; $display("FAIL cancel_abort: got flush/start/done0=%b expected 100", {bus.div_flush, bus.div_start, bus.done0}); end
    n_checks++; if (bus.stall1 !== 1'b1) begin n_fail++; $display("FAIL cancel_stall1: got %b expected 1", bus.stall1); end
    bus.cancel0 = 1'b0; bus.req0 = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.div_flush !== 1'b0) begin n_fail++; $display("FAIL cancel_flush_once: got %b expected 0", bus.div_flush); end
    @(negedge clk);
    n_checks++; if ({bus.div_start, bus.div_op1} !== {1'b1, 32'd81}) begin n_fail++; $display("FAIL cancel_regrant_pipe1: got start=%b op1=%0d expected 1/81", bus.div_start, bus.div_op1); end
    wait_done(1'b1, 60, c);
    n_checks++; if (c != 36) begin n_fail++; $display("FAIL cancel_pipe1_latency: got %0d expected 36", c); end
    n_checks++; if ({bus.hi_o, bus.lo_o, bus.done0} !== {32'd0, 32'd9, 1'b0}) begin n_fail++; $display("FAIL cancel_pipe1_result: got hi=%0d lo=%0d done0=%b expected 0/9/0", bus.hi_o, bus.lo_o, bus.done0); end
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cancel_ready();
    int seen;
    seen = 0;
    bus.req0 = 1'b1; bus.op1_0 = 32'd77; bus.op2_0 = 32'd4;
    repeat (36) @(negedge clk);
    n_checks++; if (bus.div_ready !== 1'b1) begin n_fail++; $display("FAIL cr_ready_at_cancel: got %b expected 1", bus.div_ready); end
    bus.cancel0 = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.done0, bus.div_flush} !== 2'b01) begin n_fail++; $display("FAIL cr_cancel_wins: got done0/flush=%b expected 01", {bus.done0, bus.div_flush}); end
    n_checks++; if ({bus.hi_o, bus.lo_o} !== {32'd0, 32'd9}) begin n_fail++; $display("FAIL cr_hilo_kept: got %h expected 0000000000000009", {bus.hi_o, bus.lo_o}); end
    bus.cancel0 = 1'b0; bus.req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done0 === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL cr_no_late_done: got %0d done pulses expected 0", seen); end
  endtask

  task automatic test_timeout();
    int c;
    hold = 1'b1;
    bus.req0 = 1'b1; bus.op1_0 = 32'd5; bus.op2_0 = 32'd1;
    wait_done(1'b0, 60, c);
    n_checks++; if (c != 41) begin n_fail++; $display("FAIL to_latency: got %0d expected 41", c); end
    n_checks++; if ({bus.err_o, bus.div_flush, bus.div_start} !== 3'b110) begin n_fail++; $display("FAIL to_flags: got err/flush/start=%b expected 110", {bus.err_o, bus.div_flush, bus.div_start}); end
    n_checks++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin n_fail++; $display("FAIL to_zero_result: got %h expected 0", {bus.hi_o, bus.lo_o}); end
    bus.req0 = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    n_checks++; if ({dut.state_q, bus.err_o, bus.done0} !== {IDLE, 1'b1, 1'b0}) begin n_fail++; $display("FAIL to_back_to_idle: got state/err/done0=%b expected 0010", {dut.state_q, bus.err_o, bus.done0}); end
  endtask

  task automatic test_reset_midbusy();
    int seen;
    seen = 0;
    bus.req1 = 1'b1; bus.op1_1 = 32'd9; bus.op2_1 = 32'd3;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.div_start !== 1'b1) begin n_fail++; $display("FAIL mid_busy_start: got %b expected 1", bus.div_start); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.div_start, bus.err_o} !== 2'b00) begin n_fail++; $display("FAIL mid_async_drop: got start/err=%b expected 00", {bus.div_start, bus.err_o}); end
    @(negedge clk);
    bus.req1 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done1 === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d done pulses expected 0", seen); end
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.signed0 = 1'b0; bus.signed1 = 1'b0;
    bus.op1_0 = 32'd0; bus.op2_0 = 32'd0; bus.op1_1 = 32'd0; bus.op2_1 = 32'd0;
    bus.cancel0 = 1'b0; bus.cancel1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_signed();
    test_round_robin();
    test_div_zero();
    test_cancel();
    test_cancel_ready();
    test_timeout();
    test_reset_midbusy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
